// File: rtl/tdmo.sv
// TDM output serializer: double-buffered NUM_CH x WORD_W frame store whose active
// bank is shifted out MSB-first, one bit per bit_en strobe, realigned on every fs.

module tdmo_chan #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic              wr_bank,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_bank,
  output logic [WORD_W-1:0] rd_word
);
  logic [1:0][WORD_W-1:0] bank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   bank <= '0;
    else if (wr) bank[wr_bank] <= wr_data;
  end

  assign rd_word = bank[rd_bank];
endmodule

module tdmo #(
  parameter  int NUM_CH = 32,
  parameter  int WORD_W = 8,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fs,
  input  logic              bit_en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_chan,
  input  logic [WORD_W-1:0] wr_data,
  output logic              dout,
  output logic              dout_valid,
  output logic [CH_W-1:0]   chan_idx,
  output logic              frame_err,
  input  logic              scan_in0,
  input  logic              scan_in1,
  input  logic              scan_in2,
  input  logic              scan_in3,
  input  logic              scan_in4,
  input  logic              scan_enable,
  input  logic              test_mode,
  output logic              scan_out0,
  output logic              scan_out1,
  output logic              scan_out2,
  output logic              scan_out3,
  output logic              scan_out4
);
  localparam int FRAME_BITS = NUM_CH * WORD_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int BIT_W      = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                         state, state_nxt;
  logic [CNT_W-1:0]               cnt, cnt_nxt;
  logic                           bank_sel;
  logic                           err_nxt;
  logic                           emit;
  logic                           wr_bank;
  logic [NUM_CH-1:0][WORD_W-1:0]  act_words;
  logic [CH_W-1:0]                cur_ch;
  logic [BIT_W-1:0]               bit_pos;
  logic                           rd_bit;

  // In the fs cycle the swap is simultaneous, so the post-swap shadow is the
  // bank that is active right now.
  assign wr_bank = fs ? bank_sel : ~bank_sel;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    tdmo_chan #(.WORD_W(WORD_W)) u_chan (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr_en && (wr_chan == CH_W'(i))),
      .wr_bank (wr_bank),
      .wr_data (wr_data),
      .rd_bank (bank_sel),
      .rd_word (act_words[i])
    );
  end

  assign emit    = bit_en && !fs && (state == RUN);
  assign cur_ch  = CH_W'(cnt / CNT_W'(WORD_W));
  assign bit_pos = BIT_W'(CNT_W'(WORD_W - 1) - (cnt % CNT_W'(WORD_W)));
  assign rd_bit  = act_words[cur_ch][bit_pos];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    if (fs) begin
      err_nxt   = (state == RUN) && (cnt != CNT_W'(FRAME_BITS));
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else if (emit) begin
      cnt_nxt = cnt + 1'b1;
      if (cnt == CNT_W'(FRAME_BITS - 1)) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bank_sel   <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      chan_idx   <= '0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      frame_err  <= err_nxt;
      dout_valid <= emit;
      if (fs) bank_sel <= ~bank_sel;
      if (emit) begin
        dout     <= rd_bit;
        chan_idx <= cur_ch;
      end else if (bit_en && !fs) begin
        // strobes past the end of a frame (or before the first fs) emit zeros
        dout <= 1'b0;
      end
    end
  end

  // Scan ports are stitched by the DFT flow; functionally inert here.
  logic unused_scan;
  assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode};

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;
endmodule

// File: tb/tb_tdmo.sv
// Directed bench for tdmo: frame store model plus hand-computed byte checks.

module tb_tdmo;
  logic       clk, reset, fs, bit_en, wr_en;
  logic [4:0] wr_chan;
  logic [7:0] wr_data;
  logic       dout, dout_valid, frame_err;
  logic [4:0] chan_idx;
  logic       scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mem [2][32];
  int         m_bsel, m_cnt, m_chan;
  bit         m_run;
  bit         cap [256];

  tdmo dut (
    .clk(clk), .reset(reset), .fs(fs), .bit_en(bit_en),
    .wr_en(wr_en), .wr_chan(wr_chan), .wr_data(wr_data),
    .dout(dout), .dout_valid(dout_valid), .chan_idx(chan_idx), .frame_err(frame_err),
    .scan_in0(1'b1), .scan_in1(1'b0), .scan_in2(1'b1), .scan_in3(1'b0), .scan_in4(1'b1),
    .scan_enable(1'b1), .test_mode(1'b1),
    .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
    .scan_out3(scan_out3), .scan_out4(scan_out4)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 32; c++) mem[b][c] = 8'h00;
    m_bsel = 0; m_cnt = 0; m_chan = 0; m_run = 0;
  endtask

  task automatic wr(input int ch, input logic [7:0] d);
    wr_en = 1; wr_chan = 5'(ch); wr_data = d;
    tick();
    wr_en = 0;
    mem[m_bsel ^ 1][ch] = d;
  endtask

  task automatic do_fs(input logic with_bit, input logic exp_err);
    fs = 1; bit_en = with_bit;
    m_bsel ^= 1; m_cnt = 0; m_run = 1;
    tick();
    fs = 0; bit_en = 0;
    chk("fs_frame_err", frame_err, exp_err);
    chk("fs_dout_valid", dout_valid, 0);
    tick();
    chk("frame_err_pulse", frame_err, 0);
  endtask

  task automatic emit(input int n);
    for (int i = 0; i < n; i++) begin
      int e_d, e_v, idx;
      logic [7:0] w;
      bit_en = 1;
      if (m_run) begin
        idx = m_cnt;
        w   = mem[m_bsel][m_cnt / 8];
        e_d = w[7 - m_cnt % 8];
        e_v = 1;
        m_chan = m_cnt / 8;
        m_cnt++;
        if (m_cnt == 256) m_run = 0;
      end else begin
        idx = -1; e_d = 0; e_v = 0;
      end
      tick();
      chk("dout", dout, e_d);
      chk("dout_valid", dout_valid, e_v);
      chk("chan_idx", chan_idx, m_chan);
      chk("frame_err", frame_err, 0);
      chk("scan_out", {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}, 0);
      if (idx >= 0) cap[idx] = dout;
    end
    bit_en = 0;
  endtask

  function automatic logic [7:0] cap_byte(input int ch);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[7 - k] = cap[ch * 8 + k];
    return b;
  endfunction

  function automatic logic cap_or_mid();
    logic r = 0;
    for (int k = 8; k < 248; k++) r |= cap[k];
    return r;
  endfunction

  initial begin
    reset = 1; fs = 0; bit_en = 0; wr_en = 0; wr_chan = 0; wr_data = 0;
    model_reset();
    tick(); tick();
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_chan", chan_idx, 0);
    chk("rst_err", frame_err, 0);
    reset = 0;
    tick();

    // bit_en before any fs produces nothing
    emit(3);

    // reset in the middle of a frame
    do_fs(0, 0);
    emit(100);
    #2 reset = 1;
    #1;
    chk("amid_dout", dout, 0);
    chk("amid_valid", dout_valid, 0);
    chk("amid_chan", chan_idx, 0);
    model_reset();
    tick();
    reset = 0;
    tick();
    emit(4);

    // ch0=A5, ch31=3C through two frames
    wr(0, 8'hA5);
    wr(31, 8'h3C);
    do_fs(0, 0);
    emit(256);
    chk("f1_ch0", cap_byte(0), 8'hA5);
    chk("f1_ch31", cap_byte(31), 8'h3C);
    chk("f1_mid", cap_or_mid(), 0);
    wr(0, 8'hA5);
    wr(31, 8'h3C);
    do_fs(0, 0);
    emit(256);
    chk("f2_ch0", cap_byte(0), 8'hA5);
    chk("f2_ch31", cap_byte(31), 8'h3C);
    chk("f2_mid", cap_or_mid(), 0);
    chk("f2_last_chan", chan_idx, 31);

    // shadow write during a frame stays hidden until the next fs
    do_fs(0, 0);
    wr(0, 8'hFF);
    emit(256);
    chk("iso_ch0_old", cap_byte(0), 8'hA5);
    do_fs(0, 0);
    emit(40);
    chk("iso_ch0_new", cap_byte(0), 8'hFF);

    // early fs after 40 bits
    do_fs(0, 1);
    emit(1);
    chk("early_msb", dout, 1);
    chk("early_chan", chan_idx, 0);

    // fs together with bit_en emits nothing; counter restarts
    do_fs(1, 1);
    emit(1);
    chk("sim_msb", dout, 1);
    chk("sim_valid", dout_valid, 1);

    // finish the frame, then overrun strobes
    emit(255);
    emit(10);
    chk("over_dout", dout, 0);
    chk("over_valid", dout_valid, 0);
    do_fs(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1);
  end
endmodule
